// File: rtl/line_burst_adapter.sv
// Converts cache line fill/write-back requests into fixed-length memory bursts.
// Define LINE_BURST_ERR_EN to add the sticky err_o flag for stray resp_i beats.
module line_burst_adapter #(
   parameter int unsigned LINE_W  = 256,
   parameter int unsigned BURST_W = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   input  logic [31:0]        address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [31:0]        address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
`ifdef LINE_BURST_ERR_EN
  ,output logic               err_o
`endif
);

   localparam int unsigned BEATS = LINE_W / BURST_W;
   localparam int unsigned CNT_W = $clog2(BEATS);
   localparam int unsigned OFF_W = $clog2(LINE_W / 8);
   localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t             state, state_d;
   logic [CNT_W-1:0]   count, count_d;
   logic [LINE_W-1:0]  wr_line;
   logic [31:0]        addr_q;
   logic               last_beat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_d;
         count <= count_d;
      end
   end

   always_comb begin
      state_d   = state;
      count_d   = count;
      read_o    = 1'b0;
      write_o   = 1'b0;
      resp_o    = 1'b0;
      last_beat = (count == CNT_W'(BEATS - 1));
      case (state)
         IDLE: begin
            if (write_i) begin
               state_d = WR_BURST;
               count_d = '0;
            end else if (read_i) begin
               state_d = RD_BURST;
               count_d = '0;
            end
         end
         RD_BURST: begin
            read_o = 1'b1;
            if (resp_i) begin
               count_d = count + CNT_W'(1);
               if (last_beat) state_d = DONE;
            end
         end
         WR_BURST: begin
            write_o = 1'b1;
            if (resp_i) begin
               count_d = count + CNT_W'(1);
               if (last_beat) state_d = DONE;
            end
         end
         DONE: begin
            resp_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Address is aligned at capture so address_o is a plain register view.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_line <= '0;
         addr_q  <= '0;
         line_o  <= '0;
      end else begin
         if (state == IDLE) begin
            if (write_i) begin
               wr_line <= line_i;
               addr_q  <= address_i & ADDR_MASK;
            end else if (read_i) begin
               addr_q  <= address_i & ADDR_MASK;
            end
         end
         if (state == RD_BURST && resp_i)
            line_o[count*BURST_W +: BURST_W] <= burst_i;
      end
   end

   assign address_o = addr_q;

   always_comb begin
      burst_o = '0;
      if (state == WR_BURST)
         burst_o = wr_line[count*BURST_W +: BURST_W];
   end

`ifdef LINE_BURST_ERR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err_o <= 1'b0;
      else if (resp_i && (state == IDLE || state == DONE))
         err_o <= 1'b1;
   end
`endif

endmodule

// File: doc/line_burst_adapter.md
LINE_BURST_ADAPTER -- requirements
Module: line_burst_adapter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-002 SHALL have parameter BURST_W, default 64, memory beat width in bits; BEATS = LINE_W/BURST_W, a power of two >= 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port line_i  input  LINE_W  line to write back, from the cache.
REQ-006 SHALL have port line_o  output  LINE_W  assembled fill line, to the cache.
REQ-007 SHALL have port address_i  input  32  cache-side line address.
REQ-008 SHALL have port read_i  input  1  cache requests a line fill.
REQ-009 SHALL have port write_i  input  1  cache requests a line write-back.
REQ-010 SHALL have port resp_o  output  1  one-cycle completion pulse to the cache.
REQ-011 SHALL have port burst_i  input  BURST_W  read beat from memory.
REQ-012 SHALL have port burst_o  output  BURST_W  write beat to memory.
REQ-013 SHALL have port address_o  output  32  line-aligned memory address.
REQ-014 SHALL have port read_o  output  1  memory burst read request.
REQ-015 SHALL have port write_o  output  1  memory burst write request.
REQ-016 SHALL have port resp_i  input  1  memory beat accepted/valid, one beat per cycle high.

Function
REQ-017 SHALL implement states IDLE, RD_BURST, WR_BURST, DONE.
REQ-018 IDLE: write_i high SHALL latch line_i and address_i, clear beat counter, go to WR_BURST; else read_i high SHALL latch address_i, clear counter, go to RD_BURST; write_i wins when both are high.
REQ-019 address_o SHALL equal the latched address with the low log2(LINE_W/8) bits forced to zero; it is held for the whole burst.
REQ-020 read_o SHALL be high throughout RD_BURST; write_o SHALL be high throughout WR_BURST; both SHALL be low otherwise.
REQ-021 RD_BURST: each cycle with resp_i high SHALL store burst_i into line_o slice [count*BURST_W +: BURST_W] and increment the counter; beat 0 is the least-significant slice.
REQ-022 WR_BURST: burst_o SHALL present slice [count] of the latched line; each cycle with resp_i high SHALL advance the counter.
REQ-023 Cycles with resp_i low during a burst SHALL stall the counter with no data change.
REQ-024 Acceptance of beat BEATS-1 SHALL transition to DONE; counter wraps to 0.
REQ-025 DONE SHALL assert resp_o for exactly one cycle, then return to IDLE; fill latency = BEATS beat cycles + 1.
REQ-026 line_o SHALL hold the last completed fill until the next fill overwrites it.
REQ-027 read_i/write_i SHALL be ignored outside IDLE; the cache SHALL hold them until resp_o.
REQ-028 resp_i SHALL be ignored in IDLE and DONE.
REQ-029 burst_o SHALL be 0 outside WR_BURST.

Reset
REQ-030 rst low SHALL, asynchronously, force IDLE, counter 0, line_o 0, resp_o/read_o/write_o 0, address_o 0, burst_o 0, including mid-burst; the aborted transfer is discarded.
REQ-031 The first request SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-032 With LINE_BURST_ERR_EN defined, the module SHALL add output err_o (1 bit, reset 0), set sticky on any resp_i high in IDLE or DONE and cleared only by reset.
REQ-033 Without LINE_BURST_ERR_EN, err_o SHALL not exist and stray resp_i SHALL be silently ignored.

Verification
REQ-034 Fill: address_i=0x0000_1234, read_i, resp_i 4 consecutive cycles with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220, line_o={44..,33..,22..,11..}, resp_o pulses once, 5 cycles after entering RD_BURST.
REQ-035 Write-back: line_i={D,C,B,A}, write_i, resp_i with one-cycle gap after beat 1 -> burst_o A,B,(B held),C,D; write_o high 5 cycles; resp_o once.
REQ-036 read_i and write_i both high in IDLE -> write_o asserted, read_o stays 0.
REQ-037 rst low after beat 2 of a fill -> all outputs 0 immediately, IDLE; a new fill then completes correctly.
REQ-038 With LINE_BURST_ERR_EN, resp_i pulsed in IDLE -> err_o=1 and stays 1 through a following good fill; without the macro, the same fill completes unaffected.
